// File: rtl/datapath_pkg.sv
// Shared constants for the register-bank datapath: bus source codes,
// strobe bit positions and default widths.
package datapath_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 16;

    // Bus source select codes carried on read_en.
    typedef enum logic [3:0] {
        SRC_HOLD = 4'd0,
        SRC_PC   = 4'd1,
        SRC_AR   = 4'd2,
        SRC_DR   = 4'd3,
        SRC_IR   = 4'd4,
        SRC_AC   = 4'd5,
        SRC_R    = 4'd6,
        SRC_R1   = 4'd7,
        SRC_R2   = 4'd8,
        SRC_R3   = 4'd9,
        SRC_R4   = 4'd10,
        SRC_R5   = 4'd11,
        SRC_DM   = 4'd12,
        SRC_IM   = 4'd13,
        SRC_AC_R = 4'd14,
        SRC_ZERO = 4'd15
    } src_e;

    // write_en bit positions.
    localparam int WB_PC     = 1;
    localparam int WB_AR     = 2;
    localparam int WB_IR     = 3;
    localparam int WB_AC     = 4;
    localparam int WB_R      = 5;
    localparam int WB_R4     = 6;
    localparam int WB_R3     = 7;
    localparam int WB_R2     = 8;
    localparam int WB_R1     = 9;
    localparam int WB_DM     = 11;
    localparam int WB_ALU_AC = 12;
    localparam int WB_AC_R   = 13;

    // inc_en / clr_en bit positions.
    localparam int IB_PC = 1;
    localparam int IB_AC = 4;
    localparam int CB_PC = 1;
    localparam int CB_AR = 2;
    localparam int CB_AC = 4;

endpackage

// File: rtl/datapath_regs_reg16_cwi.sv
// Register with clear, write and increment controls.
// Fixed priority: reset > clear > write > increment; increment wraps modulo 2^W.
module reg16_cwi
    import datapath_pkg::*;
#(
    parameter int W = DW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         we_i,
    input  logic         inc_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Prioritised clear / load / increment of the stored value.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (we_i) begin
            q_q <= d_i;
        end else if (inc_i) begin
            q_q <= q_q + W'(1);
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/datapath_regs.sv
// Register bank and registered shared bus sitting under the control unit.
// A read edge loads bus_q from the selected source; a following write edge
// moves the old bus_q value into the strobed destinations.
module datapath_regs
    import datapath_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    read_en,
    input  logic [15:0]   write_en,
    input  logic [15:0]   inc_en,
    input  logic [15:0]   clr_en,
    input  logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] im_data,
    input  logic [DW-1:0] dm_rdata,
    output logic [AW-1:0] im_addr,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_we,
    output logic [DW-1:0] ac_o,
    output logic [DW-1:0] r_o,
    output logic [2:0]    alu_op_o,
    output logic [5:0]    instruction,
    output logic [15:0]   z
);

    logic [DW-1:0] bus_q, bus_d;
    logic [DW-1:0] pc_q, ar_q, ac_q;
    logic [DW-1:0] dr_q, ir_q, r_q, r1_q, r2_q, r3_q, r4_q;
    logic          ac_we;
    logic [DW-1:0] ac_d;

    // Bus source select; code 0 holds, R5 and code 15 read as zero.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves bus_d unassigned (no latch).
        bus_d = bus_q;
        case (src_e'(read_en))
            SRC_HOLD: bus_d = bus_q;
            SRC_PC:   bus_d = pc_q;
            SRC_AR:   bus_d = ar_q;
            SRC_DR:   bus_d = dr_q;
            SRC_IR:   bus_d = ir_q;
            SRC_AC:   bus_d = ac_q;
            SRC_R:    bus_d = r_q;
            SRC_R1:   bus_d = r1_q;
            SRC_R2:   bus_d = r2_q;
            SRC_R3:   bus_d = r3_q;
            SRC_R4:   bus_d = r4_q;
            SRC_R5:   bus_d = '0;
            SRC_DM:   bus_d = dm_rdata;
            SRC_IM:   bus_d = im_data;
            SRC_AC_R: bus_d = ac_q;
            SRC_ZERO: bus_d = '0;
            default:  bus_d = bus_q;
        endcase
    end

    // ALU result has priority over the bus when both AC loads are strobed.
    assign ac_we = write_en[WB_AC] | write_en[WB_ALU_AC];
    assign ac_d  = write_en[WB_ALU_AC] ? alu_result : bus_q;

    reg16_cwi #(.W(DW)) u_pc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_en[CB_PC]),
        .we_i  (write_en[WB_PC]),
        .inc_i (inc_en[IB_PC]),
        .d_i   (bus_q),
        .q_o   (pc_q)
    );

    reg16_cwi #(.W(DW)) u_ar (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_en[CB_AR]),
        .we_i  (write_en[WB_AR]),
        .inc_i (1'b0),
        .d_i   (bus_q),
        .q_o   (ar_q)
    );

    reg16_cwi #(.W(DW)) u_ac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_en[CB_AC]),
        .we_i  (ac_we),
        .inc_i (inc_en[IB_AC]),
        .d_i   (ac_d),
        .q_o   (ac_q)
    );

    // Bus register, DR mirror and plain load registers; destinations take the pre-edge bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= '0;
            dr_q  <= '0;
            ir_q  <= '0;
            r_q   <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
            r4_q  <= '0;
        end else begin
            if (read_en != 4'd0)            bus_q <= bus_d;
            if (src_e'(read_en) == SRC_DM)  dr_q  <= dm_rdata;
            if (write_en[WB_IR])            ir_q  <= bus_q;
            // The direct AC->R path wins if both R loads are strobed together.
            if (write_en[WB_AC_R])          r_q   <= ac_q;
            else if (write_en[WB_R])        r_q   <= bus_q;
            if (write_en[WB_R1])            r1_q  <= bus_q;
            if (write_en[WB_R2])            r2_q  <= bus_q;
            if (write_en[WB_R3])            r3_q  <= bus_q;
            if (write_en[WB_R4])            r4_q  <= bus_q;
        end
    end

    // Strobe bits with no destination in this block.
    logic unused_strobes;
    assign unused_strobes = ^{write_en[0], write_en[10], write_en[15:14],
                              inc_en[15:5], inc_en[3:2], inc_en[0],
                              clr_en[15:5], clr_en[3], clr_en[0]};

    assign im_addr     = pc_q[AW-1:0];
    assign dm_addr     = ar_q[AW-1:0];
    assign dm_wdata    = bus_q;
    assign dm_we       = write_en[WB_DM];
    assign ac_o        = ac_q;
    assign r_o         = r_q;
    assign alu_op_o    = alu_op;
    assign instruction = ir_q[5:0];
    assign z           = {15'b0, (ac_q == '0)};

endmodule

// File: tb/tb_datapath_regs.sv
// Self-checking bench for datapath_regs: directed scenarios followed by
// randomized strobes, all compared against a behavioural register-bank model.
module tb_datapath_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  read_en;
    logic [15:0] write_en, inc_en, clr_en;
    logic [2:0]  alu_op;
    logic [15:0] alu_result, im_data, dm_rdata;
    logic [15:0] im_addr, dm_addr, dm_wdata;
    logic        dm_we;
    logic [15:0] ac_o, r_o;
    logic [2:0]  alu_op_o;
    logic [5:0]  instruction;
    logic [15:0] z;

    int total = 0;
    int bad   = 0;

    // Model state.
    logic [15:0] m_pc, m_ar, m_dr, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4, m_bus;

    datapath_regs #(.DW(16), .AW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .read_en     (read_en),
        .write_en    (write_en),
        .inc_en      (inc_en),
        .clr_en      (clr_en),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .im_data     (im_data),
        .dm_rdata    (dm_rdata),
        .im_addr     (im_addr),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_we       (dm_we),
        .ac_o        (ac_o),
        .r_o         (r_o),
        .alu_op_o    (alu_op_o),
        .instruction (instruction),
        .z           (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural view of one rising edge, using the inputs present before it.
    task automatic model_edge();
        logic [15:0] src [16];
        logic [15:0] b;
        logic [15:0] n_pc, n_ar, n_ac, n_r;
        if (rst) begin
            {m_pc, m_ar, m_dr, m_ir, m_ac, m_r} = '0;
            {m_r1, m_r2, m_r3, m_r4, m_bus}     = '0;
            return;
        end
        b = m_bus;
        src[0]  = m_bus;   src[1]  = m_pc;  src[2]  = m_ar;     src[3]  = m_dr;
        src[4]  = m_ir;    src[5]  = m_ac;  src[6]  = m_r;      src[7]  = m_r1;
        src[8]  = m_r2;    src[9]  = m_r3;  src[10] = m_r4;     src[11] = 16'h0;
        src[12] = dm_rdata; src[13] = im_data; src[14] = m_ac;  src[15] = 16'h0;

        n_pc = m_pc;
        if (clr_en[1])        n_pc = 16'h0;
        else if (write_en[1]) n_pc = b;
        else if (inc_en[1])   n_pc = m_pc + 16'd1;

        n_ar = m_ar;
        if (clr_en[2])        n_ar = 16'h0;
        else if (write_en[2]) n_ar = b;

        n_ac = m_ac;
        if (clr_en[4])         n_ac = 16'h0;
        else if (write_en[12]) n_ac = alu_result;
        else if (write_en[4])  n_ac = b;
        else if (inc_en[4])    n_ac = m_ac + 16'd1;

        n_r = m_r;
        if (write_en[13])     n_r = m_ac;
        else if (write_en[5]) n_r = b;

        if (write_en[3]) m_ir = b;
        if (write_en[9]) m_r1 = b;
        if (write_en[8]) m_r2 = b;
        if (write_en[7]) m_r3 = b;
        if (write_en[6]) m_r4 = b;
        if (read_en == 4'd12) m_dr = dm_rdata;
        m_bus = src[read_en];
        m_pc = n_pc; m_ar = n_ar; m_ac = n_ac; m_r = n_r;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".im_addr"},     im_addr,     m_pc);
        check({tag, ".dm_addr"},     dm_addr,     m_ar);
        check({tag, ".bus"},         dm_wdata,    m_bus);
        check({tag, ".ac"},          ac_o,        m_ac);
        check({tag, ".r"},           r_o,         m_r);
        check({tag, ".instruction"}, instruction, m_ir[5:0]);
        check({tag, ".z"},           z,           (m_ac == 16'h0) ? 16'h0001 : 16'h0000);
        check({tag, ".dm_we"},       dm_we,       write_en[11]);
        check({tag, ".alu_op_o"},    alu_op_o,    alu_op);
    endtask

    task automatic set_in(input logic r, input logic [3:0] re, input logic [15:0] we,
                          input logic [15:0] inc, input logic [15:0] clr);
        rst = r; read_en = re; write_en = we; inc_en = inc; clr_en = clr;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    localparam logic [15:0] B1 = 16'h0002, B2 = 16'h0004, B3 = 16'h0008, B4 = 16'h0010;
    localparam logic [15:0] B5 = 16'h0020, B9 = 16'h0200, B11 = 16'h0800, B12 = 16'h1000;

    initial begin
        alu_op = 3'd0; alu_result = '0; im_data = '0; dm_rdata = '0;
        {m_pc, m_ar, m_dr, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4, m_bus} = '0;
        set_in(1'b1, 4'd0, 16'h0, 16'h0, 16'h0);
        @(posedge clk); model_edge(); #1;
        tick("reset");
        check("reset.z", z, 16'h0001);
        check("reset.instruction", instruction, 6'd0);
        check("reset.bus", dm_wdata, 16'h0);

        // Clear PC and AR.
        set_in(1'b0, 4'd0, 16'h0, 16'h0, B1 | B2);
        tick("clr");
        check("clr.im_addr", im_addr, 16'h0);
        check("clr.dm_addr", dm_addr, 16'h0);

        // Fetch: im_data onto bus, then into IR.
        im_data = 16'h0013;
        set_in(1'b0, 4'd13, 16'h0, 16'h0, 16'h0); tick("fetch_rd");
        set_in(1'b0, 4'd0, B3, 16'h0, 16'h0);     tick("fetch_wr");
        check("fetch.instruction", instruction, 6'd19);

        // AC=5 via ALU, copy to R1, then back to AC.
        alu_result = 16'd5;
        set_in(1'b0, 4'd0, B12, 16'h0, 16'h0);    tick("ac5");
        set_in(1'b0, 4'd14, 16'h0, 16'h0, 16'h0); tick("r1_rd");
        set_in(1'b0, 4'd0, B9, 16'h0, 16'h0);     tick("r1_wr");
        set_in(1'b0, 4'd7, 16'h0, 16'h0, 16'h0);  tick("r1_back_rd");
        check("r1.bus", dm_wdata, 16'd5);
        set_in(1'b0, 4'd0, B4, 16'h0, 16'h0);     tick("r1_back_wr");
        check("r1.ac", ac_o, 16'd5);
        check("r1.z", z, 16'h0);

        // PC wrap and priority.
        alu_result = 16'hFFFF;
        set_in(1'b0, 4'd0, B12, 16'h0, 16'h0);    tick("pcff_alu");
        set_in(1'b0, 4'd5, 16'h0, 16'h0, 16'h0);  tick("pcff_rd");
        set_in(1'b0, 4'd0, B1, 16'h0, 16'h0);     tick("pcff_wr");
        check("pc.ffff", im_addr, 16'hFFFF);
        set_in(1'b0, 4'd0, 16'h0, B1, 16'h0);     tick("pc_wrap");
        check("pc.wrap", im_addr, 16'h0000);
        alu_result = 16'h0040;
        set_in(1'b0, 4'd0, B12, 16'h0, 16'h0);    tick("pc40_alu");
        set_in(1'b0, 4'd5, 16'h0, 16'h0, 16'h0);  tick("pc40_rd");
        set_in(1'b0, 4'd0, B1, B1, 16'h0);        tick("pc_wr_inc");
        check("pc.write_over_inc", im_addr, 16'h0040);
        set_in(1'b0, 4'd0, B1, B1, B1);           tick("pc_clr_all");
        check("pc.clr_over_all", im_addr, 16'h0000);

        // Data memory store.
        alu_result = 16'h1234;
        set_in(1'b0, 4'd0, B12, 16'h0, 16'h0);    tick("st_alu");
        set_in(1'b0, 4'd5, 16'h0, 16'h0, 16'h0);  tick("st_rd");
        set_in(1'b0, 4'd0, B11, 16'h0, 16'h0);    #1;
        check("st.dm_we", dm_we, 1'b1);
        check("st.dm_wdata", dm_wdata, 16'h1234);
        tick("st_wr");
        set_in(1'b0, 4'd0, 16'h0, 16'h0, 16'h0);  #1;
        check("st.dm_we_drop", dm_we, 1'b0);

        // Data memory load into AC.
        dm_rdata = 16'h00AA;
        set_in(1'b0, 4'd12, 16'h0, 16'h0, 16'h0); tick("ld_rd");
        set_in(1'b0, 4'd0, B4, 16'h0, 16'h0);     tick("ld_wr");
        check("ld.ac", ac_o, 16'h00AA);
        set_in(1'b0, 4'd3, 16'h0, 16'h0, 16'h0);  tick("dr_rd");
        check("dr.bus", dm_wdata, 16'h00AA);

        // Reset in the middle of an AC->R transfer.
        alu_result = 16'd7;
        set_in(1'b0, 4'd0, B12, 16'h0, 16'h0);    tick("mr_alu");
        set_in(1'b0, 4'd5, 16'h0, 16'h0, 16'h0);  tick("mr_rd");
        set_in(1'b1, 4'd0, B5, 16'h0, 16'h0);     tick("mr_rst");
        check("midreset.r", r_o, 16'h0);
        check("midreset.bus", dm_wdata, 16'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            alu_op     = 3'($urandom);
            alu_result = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            im_data    = 16'($urandom);
            dm_rdata   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            set_in(($urandom_range(0, 59) == 0),
                   4'($urandom),
                   16'($urandom & $urandom & $urandom),
                   16'($urandom & $urandom & $urandom),
                   16'($urandom & $urandom & $urandom & $urandom));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
